// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared types and defaults for the operand register-file control sequencer.
//   rc_state_e         : sequencer state encoding (IDLE, COLLECT, FIRE, WAIT_FU)
//   RC_TIMEOUT_CYCLES  : default FU watchdog limit (used only with REGFILE_CTRL_TIMEOUT_EN)
//   RC_CNT_W           : default width of the completed-operation counter
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIRE    = 2'd2,
        WAIT_FU = 2'd3
    } rc_state_e;

    localparam int RC_TIMEOUT_CYCLES = 64;
    localparam int RC_CNT_W          = 16;

endpackage

// File: rtl/regfile_ctrl_wdog.sv
// regfile_ctrl_wdog
// Cycle watchdog for the WAIT_FU state. Built only when REGFILE_CTRL_TIMEOUT_EN
// is defined.
// Ports:
//   clk      in  : tile clock
//   reset_n  in  : asynchronous active-low reset
//   clr_i    in  : restart the count (asserted in the cycle before WAIT_FU entry)
//   en_i     in  : count this cycle (asserted while in WAIT_FU)
//   expire_o out : high in the LIMIT-th enabled cycle since the last clear
module regfile_ctrl_wdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of enabled cycles already elapsed, so the
    // LIMIT-th one is the cycle where it reads LIMIT-1.
    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl
// Control sequencer for the vector tile's operand register file. Collects two
// operand vectors and a config word via valid/ready, drives the register-file
// write/read enables, launches the vector FU and holds read mode until done.
// Optional feature macro: REGFILE_CTRL_TIMEOUT_EN (FU watchdog, drives to_err).
// Ports:
//   clk, reset_n                  : tile clock, async active-low reset
//   n1_valid/n1_ready             : neighbor-1 operand handshake
//   n2_valid/n2_ready             : neighbor-2 operand handshake
//   cfg_valid/cfg_ready           : config word handshake
//   rf_wen1/rf_wen2/rf_wen3       : register-file write enables
//   rf_ren                        : register-file read enable
//   rf_wr_ack                     : write ack, one cycle after each write
//   fu_start / fu_done            : FU launch pulse / completion pulse
//   busy                          : high in FIRE and WAIT_FU
//   op_count                      : completed operations (wraps)
//   ack_err / to_err              : sticky missing-ack / FU-timeout errors
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = RC_TIMEOUT_CYCLES,
    parameter int CNT_W          = RC_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             n1_valid,
    output logic             n1_ready,
    input  logic             n2_valid,
    output logic             n2_ready,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             rf_wen1,
    output logic             rf_wen2,
    output logic             rf_wen3,
    output logic             rf_ren,
    input  logic             rf_wr_ack,
    output logic             fu_start,
    input  logic             fu_done,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             ack_err,
    output logic             to_err
);

    rc_state_e        state_q, state_d;
    logic             have1_q, have1_d;
    logic             have2_q, have2_d;
    logic             have_cfg_q, have_cfg_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             wen_any_q;
    logic             ack_err_q;
    logic             wd_expire;

`ifdef REGFILE_CTRL_TIMEOUT_EN
    logic to_err_q;

    // FIRE always precedes WAIT_FU, so clearing there restarts the count on entry.
    regfile_ctrl_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (state_q == FIRE),
        .en_i     (state_q == WAIT_FU),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_err_q <= 1'b0;
        end else if (state_q == WAIT_FU && wd_expire && !fu_done) begin
            to_err_q <= 1'b1;
        end
    end

    assign to_err = to_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_expire      = 1'b0;
    assign to_err         = 1'b0;
`endif

    // Readies depend only on registered state/flags: no valid->ready path.
    always_comb begin
        n1_ready  = (state_q == COLLECT) && !have1_q;
        n2_ready  = (state_q == COLLECT) && !have2_q;
        cfg_ready = (state_q == COLLECT);
        rf_wen1   = n1_valid  && n1_ready;
        rf_wen2   = n2_valid  && n2_ready;
        rf_wen3   = cfg_valid && cfg_ready;
    end

    always_comb begin
        state_d    = state_q;
        have1_d    = have1_q | rf_wen1;
        have2_d    = have2_q | rf_wen2;
        have_cfg_d = have_cfg_q | rf_wen3;
        op_count_d = op_count_q;
        case (state_q)
            IDLE:    state_d = COLLECT;
            COLLECT: begin
                if (have1_d && have2_d && have_cfg_d) begin
                    state_d = FIRE;
                end
            end
            FIRE:    state_d = WAIT_FU;
            WAIT_FU: begin
                // fu_done wins over a same-cycle watchdog expiry.
                if (fu_done) begin
                    have1_d    = 1'b0;
                    have2_d    = 1'b0;
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = COLLECT;
                end else if (wd_expire) begin
                    have1_d = 1'b0;
                    have2_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            have1_q    <= 1'b0;
            have2_q    <= 1'b0;
            have_cfg_q <= 1'b0;
            op_count_q <= '0;
            wen_any_q  <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            have1_q    <= have1_d;
            have2_q    <= have2_d;
            have_cfg_q <= have_cfg_d;
            op_count_q <= op_count_d;
            // A write in the previous cycle must be acked in this one.
            wen_any_q  <= rf_wen1 | rf_wen2 | rf_wen3;
            if (wen_any_q && !rf_wr_ack) begin
                ack_err_q <= 1'b1;
            end
        end
    end

    assign fu_start = (state_q == FIRE);
    assign rf_ren   = (state_q == FIRE) || (state_q == WAIT_FU);
    assign busy     = rf_ren;
    assign op_count = op_count_q;
    assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;

    localparam int CNT_W = 16;
    localparam int NVEC  = 18;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             n1_valid, n2_valid, cfg_valid;
    logic             n1_ready, n2_ready, cfg_ready;
    logic             rf_wen1, rf_wen2, rf_wen3, rf_ren;
    logic             rf_wr_ack, fu_start, fu_done, busy;
    logic [CNT_W-1:0] op_count;
    logic             ack_err, to_err;

    int tests = 0;
    int fails = 0;

    regfile_ctrl #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .n1_valid  (n1_valid),
        .n1_ready  (n1_ready),
        .n2_valid  (n2_valid),
        .n2_ready  (n2_ready),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .rf_wen1   (rf_wen1),
        .rf_wen2   (rf_wen2),
        .rf_wen3   (rf_wen3),
        .rf_ren    (rf_ren),
        .rf_wr_ack (rf_wr_ack),
        .fu_start  (fu_start),
        .fu_done   (fu_done),
        .busy      (busy),
        .op_count  (op_count),
        .ack_err   (ack_err),
        .to_err    (to_err)
    );

    always #5 clk = ~clk;

    // in  = {n1_valid, n2_valid, cfg_valid, rf_wr_ack, fu_done}
    // exp = {n1_ready, n2_ready, cfg_ready, wen1, wen2, wen3, fu_start, rf_ren, busy, ack_err, to_err}
    typedef struct {
        logic [4:0]  in;
        logic [10:0] exp;
        int          cnt;
    } vec_t;

    vec_t vec [NVEC];

    function automatic logic [10:0] outs();
        return {n1_ready, n2_ready, cfg_ready, rf_wen1, rf_wen2, rf_wen3,
                fu_start, rf_ren, busy, ack_err, to_err};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // Reset + IDLE, same-cycle collection, backpressure while busy,
        // staggered collection with ignored fu_done, sticky config, missing ack.
        vec[0]  = '{5'b11110, 11'b00000000000, 0};
        vec[1]  = '{5'b00010, 11'b11100000000, 0};
        vec[2]  = '{5'b11110, 11'b11111100000, 0};
        vec[3]  = '{5'b11110, 11'b00000011100, 0};
        vec[4]  = '{5'b11110, 11'b00000001100, 0};
        vec[5]  = '{5'b11111, 11'b00000001100, 0};
        vec[6]  = '{5'b10010, 11'b11110000000, 1};
        vec[7]  = '{5'b10011, 11'b01100000000, 1};
        vec[8]  = '{5'b01010, 11'b01101000000, 1};
        vec[9]  = '{5'b00010, 11'b00000011100, 1};
        vec[10] = '{5'b00010, 11'b00000001100, 1};
        vec[11] = '{5'b00011, 11'b00000001100, 1};
        vec[12] = '{5'b00110, 11'b11100100000, 2};
        vec[13] = '{5'b00000, 11'b11100000000, 2};
        vec[14] = '{5'b11010, 11'b11111000010, 2};
        vec[15] = '{5'b00010, 11'b00000011110, 2};
        vec[16] = '{5'b00011, 11'b00000001110, 2};
        vec[17] = '{5'b00010, 11'b11100000010, 3};

        reset_n   = 1'b0;
        n1_valid  = 1'b1;
        n2_valid  = 1'b1;
        cfg_valid = 1'b1;
        rf_wr_ack = 1'b1;
        fu_done   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", int'(outs()), 0);
        chk("reset_cnt", int'(op_count), 0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            {n1_valid, n2_valid, cfg_valid, rf_wr_ack, fu_done} = vec[i].in;
            #1;
            chk($sformatf("vec%0d_outs", i), int'(outs()), int'(vec[i].exp));
            chk($sformatf("vec%0d_cnt", i), int'(op_count), vec[i].cnt);
            @(negedge clk);
        end

        // Asynchronous abort from WAIT_FU.
        {n1_valid, n2_valid, cfg_valid, rf_wr_ack, fu_done} = 5'b11010;
        @(negedge clk);
        n1_valid = 1'b0;
        n2_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_pre_ren", int'(rf_ren), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_ren", int'(rf_ren), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ackerr", int'(ack_err), 0);
        chk("abort_cnt", int'(op_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_idle_ready", int'(n1_ready), 0);
        @(negedge clk);
        #1;
        chk("rel_collect_ready", int'(cfg_ready), 1);

        // Config was lost in the abort: operands alone must not fire.
        n1_valid = 1'b1;
        n2_valid = 1'b1;
        #1;
        chk("nocfg_wen", int'({rf_wen1, rf_wen2, rf_wen3}), 3'b110);
        @(negedge clk);
        n1_valid = 1'b0;
        n2_valid = 1'b0;
        #1;
        chk("nocfg_nostart", int'(fu_start), 0);
        chk("nocfg_n1ready", int'(n1_ready), 0);
        cfg_valid = 1'b1;
        #1;
        chk("cfg_wen3", int'(rf_wen3), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("cfg_start", int'(fu_start), 1);

        // Never assert fu_done for 8 WAIT_FU cycles.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("wait%0d_ren", i), int'(rf_ren), 1);
            chk($sformatf("wait%0d_toerr", i), int'(to_err), 0);
        end
        @(negedge clk);
        #1;
`ifdef REGFILE_CTRL_TIMEOUT_EN
        chk("to_err_set", int'(to_err), 1);
        chk("to_busy", int'(busy), 0);
        chk("to_n1ready", int'(n1_ready), 1);
        chk("to_cnt", int'(op_count), 0);
        n1_valid = 1'b1;
        n2_valid = 1'b1;
        @(negedge clk);
        n1_valid = 1'b0;
        n2_valid = 1'b0;
        #1;
        chk("to_cfg_sticky_start", int'(fu_start), 1);
`else
        chk("noto_toerr", int'(to_err), 0);
        chk("noto_busy", int'(busy), 1);
        fu_done = 1'b1;
        @(negedge clk);
        fu_done = 1'b0;
        #1;
        chk("noto_cnt", int'(op_count), 1);
        chk("noto_n1ready", int'(n1_ready), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Control sequencer for the vector tile's operand register file: it accepts operand vectors from the two CGRA neighbor links and a config word through valid/ready handshakes. It drives the register file's three write enables and its read enable. Once both operand sets and a config are resident, it launches the vector FU and holds the register file in read mode until the FU finishes. It sits between the tile's network interfaces, the register file and the vector FU. It carries control only; data goes straight from the links to the register file.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in WAIT_FU. Only used with the timeout feature.
- `CNT_W`, default 16: width of `op_count`.
- `clk` in 1: tile clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `n1_valid` in 1 / `n1_ready` out 1: neighbor-1 operand vector handshake.
- `n2_valid` in 1 / `n2_ready` out 1: neighbor-2 operand vector handshake.
- `cfg_valid` in 1 / `cfg_ready` out 1: config word handshake.
- `rf_wen1`, `rf_wen2`, `rf_wen3` out 1: register file write enables, one per write port.
- `rf_ren` out 1: register file read enable.
- `rf_wr_ack` in 1: write acknowledge from the register file, returned one cycle after any write.
- `fu_start` out 1: single-cycle FU launch pulse.
- `fu_done` in 1: FU completion pulse.
- `busy` out 1: high in FIRE and WAIT_FU.
- `op_count` out `CNT_W`: number of completed operations.
- `ack_err` out 1: sticky; set when a write received no ack.
- `to_err` out 1: sticky; FU timeout. Tied to 0 when the timeout feature is compiled out.

## Operation
- State register values: IDLE, COLLECT, FIRE, WAIT_FU.
- Flag registers: `have1`, `have2`, `have_cfg`.
- Reset (asynchronous): state=IDLE, all flags 0, `op_count`=0, `ack_err`=0, `to_err`=0. Every output reads 0.
- IDLE → COLLECT unconditionally on the next clock edge. This guarantees the readies stay low for at least one cycle after reset release.
- COLLECT:
  - `n1_ready`=!`have1`; `n2_ready`=!`have2`; `cfg_ready`=1. All readies are 0 in every other state.
  - `rf_wenX` = valid & ready of the matching link (combinational).
  - A handshake sets the matching flag.
  - A config handshake while `have_cfg`=1 overwrites the resident config.
- COLLECT → FIRE when the next-cycle values of all three flags are 1. All three handshakes may complete in the same cycle.
- FIRE (exactly one cycle): `fu_start`=1, `rf_ren`=1. Next state is WAIT_FU.
- WAIT_FU:
  - `rf_ren` held at 1, so the FU sees stable operands and the register file blocks writes.
  - On `fu_done`: clear `have1` and `have2` (`have_cfg` is sticky), increment `op_count` (wraps modulo 2^`CNT_W`), go to COLLECT.
- `fu_done` is ignored in every state except WAIT_FU.
- Ack check: if any `rf_wenX` was high in cycle t and `rf_wr_ack`=0 in cycle t+1, set `ack_err`. It clears only on reset.
- Asserting reset mid-operation aborts immediately. Flags are lost and `rf_ren` drops asynchronously.

## Timing
- Last handshake in cycle t → `fu_start` and `rf_ren` high in t+1. The register file has captured the write at the t edge.
- `fu_done` in cycle d → state COLLECT and readies available in d+1; `op_count` updates in d+1.
- Minimum operation period: 3 cycles (handshake, FIRE, WAIT_FU with `fu_done`).
- Readies are combinational from registered state and flags only. There is no valid→ready combinational path.

## Configuration
- Macro: `REGFILE_CTRL_TIMEOUT_EN`.
- Defined:
  - A watchdog counts cycles in WAIT_FU, clearing on entry.
  - On reaching `TIMEOUT_CYCLES` without `fu_done`: set `to_err`, clear `have1` and `have2`, do not increment `op_count`, go to COLLECT.
  - `fu_done` in the same cycle as expiry wins; it is treated as normal completion.
- Undefined: no counter is built, `to_err` is tied to 0, and WAIT_FU waits indefinitely.

## Structure
- Package `regfile_ctrl_pkg` holds:
  - the state enum `rc_state_e` (IDLE, COLLECT, FIRE, WAIT_FU);
  - the default `TIMEOUT_CYCLES` constant;
  - the `CNT_W` default.
- One sub-module, `regfile_ctrl_wdog`:
  - watchdog counter with a clear input, an enable input and an expiry output;
  - instantiated only under `REGFILE_CTRL_TIMEOUT_EN`.

## Test plan
- **Reset and IDLE:** hold `reset_n` low, then release. All outputs are 0 during reset; readies are 0 in the first cycle after release and 1 in the second.
- **Same-cycle collection:** `n1_valid`, `n2_valid` and `cfg_valid` all high in cycle 5 → `rf_wen1`, `rf_wen2` and `rf_wen3` high in cycle 5; `fu_start` and `rf_ren` high in cycle 6; `rf_wr_ack` expected in cycle 6.
- **Staggered collection and sticky config:**
  - n1 in cycle 3, cfg in cycle 4, n2 in cycle 7 → `fu_start` in cycle 8.
  - `fu_done` in cycle 12 → `op_count`=1 in cycle 13.
  - A second n1 and n2 pair with no new cfg → FU fires again.
- **Backpressure while busy:** hold all valids high during WAIT_FU → all readies 0 and no `rf_wenX` until the cycle after `fu_done`.
- **Missing ack:** force `rf_wr_ack`=0 after a write → `ack_err`=1 in the following cycle, and it stays set until reset.
- **Timeout** (`REGFILE_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): never assert `fu_done` → `to_err`=1 after 8 WAIT_FU cycles, state returns to COLLECT, `op_count` is unchanged and `have_cfg` is still 1.
